// File: rtl/spi_pkg.sv
// Shared types and pin map for the buffered PMOD SPI master.
// Engine state encoding, dout bit positions, active-low levels.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_TRANS = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  localparam int PIN_CS   = 0;
  localparam int PIN_SDO  = 1;
  localparam int PIN_ZERO = 2;
  localparam int PIN_SCK  = 3;
  localparam int PIN_DC   = 4;
  localparam int PIN_RES  = 5;
  localparam int PIN_VCC  = 6;
  localparam int PIN_PMOD = 7;

  localparam logic LO_ENABLE  = 1'b0;
  localparam logic LO_DISABLE = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; an extra pointer bit separates full from empty.
// Push is ignored when full, pop is ignored when empty.
import spi_pkg::*;

module sync_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign level = LVL_W'(wp - rp);
  assign dout  = mem[rp[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/spi_master_fifo.sv
// Buffered SPI master for the PMOD OLED: TX FIFO drained by a shift engine.
// Define SPI_MASTER_BURST_EN to chain same-D/C data bytes under one cs_ low.
import spi_pkg::*;

module spi_master_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int FREQDIV    = 50,
  parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk_125mhz,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [DATA_W+1:0] wr_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level,
  output logic             busy,
  output logic             ovf,
  output logic [7:0]       dout
);

  localparam int FW    = DATA_W + 2;
  localparam int DIV_W = $clog2(FREQDIV);
  localparam int CNT_W = $clog2(DATA_W + 1);

  state_t            state;
  logic [FW-1:0]     head;
  logic              pop;
  logic              burst;
  logic              frame_end;
  logic              div_done;
  logic [DIV_W-1:0]  div;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;
  logic              cs;
  logic              res;
  logic              dc;
  logic              sck;
  logic              sdo;
  logic              pmod;
  logic              vcc;

  sync_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk   (clk_125mhz),
    .reset (reset),
    .push  (wr_en),
    .pop   (pop),
    .din   (wr_data),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign div_done  = (div == DIV_W'(FREQDIV - 1));
  assign frame_end = (state == ST_TRANS) && !sck &&
                     div_done && (cnt == '0);

`ifdef SPI_MASTER_BURST_EN
  assign burst = frame_end && !empty &&
                 !head[DATA_W+1] && (head[DATA_W] == dc);
`else
  assign burst = 1'b0;
`endif

  assign pop  = !empty && ((state == ST_IDLE) || burst);
  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk_125mhz or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (wr_en && full) begin
      ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk_125mhz or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cs    <= LO_DISABLE;
      res   <= LO_ENABLE;
      dc    <= 1'b0;
      sck   <= 1'b0;
      sdo   <= 1'b0;
      pmod  <= 1'b0;
      vcc   <= 1'b0;
      shreg <= '0;
      cnt   <= '0;
      div   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          res <= LO_DISABLE;
          sck <= 1'b1;
          div <= '0;
          if (!empty) begin
            if (head[DATA_W+1]) begin
              pmod <= 1'b1;
              vcc  <= 1'b1;
            end else begin
              shreg <= head[DATA_W-1:0];
              dc    <= head[DATA_W];
              cs    <= LO_ENABLE;
              cnt   <= CNT_W'(DATA_W);
              state <= ST_START;
            end
          end
        end
        ST_START: begin
          if (div_done) begin
            div   <= '0;
            state <= ST_TRANS;
          end else begin
            div <= div + 1'b1;
          end
        end
        ST_TRANS: begin
          if (!div_done) begin
            div <= div + 1'b1;
          end else begin
            div <= '0;
            if (sck) begin
              sck <= 1'b0;
              sdo <= shreg[DATA_W-1];
              cnt <= cnt - 1'b1;
            end else begin
              sck   <= 1'b1;
              shreg <= shreg << 1;
              // Chained byte reloads here so spacing stays 2*DATA_W*FREQDIV.
              if (burst) begin
                shreg <= head[DATA_W-1:0];
                cnt   <= CNT_W'(DATA_W);
              end else if (cnt == '0) begin
                state <= ST_STOP;
              end
            end
          end
        end
        ST_STOP: begin
          if (div_done) begin
            div   <= '0;
            cs    <= LO_DISABLE;
            state <= ST_IDLE;
          end else begin
            div <= div + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    dout           = '0;
    dout[PIN_CS]   = cs;
    dout[PIN_SDO]  = sdo;
    dout[PIN_ZERO] = 1'b0;
    dout[PIN_SCK]  = sck;
    dout[PIN_DC]   = dc;
    dout[PIN_RES]  = res;
    dout[PIN_VCC]  = vcc;
    dout[PIN_PMOD] = pmod;
  end

  logic unused_frame_end;
  assign unused_frame_end = frame_end;

endmodule

// File: tb/tb_spi_master_fifo.sv
// Directed bench for spi_master_fifo with hand-computed expectations.
// A negedge monitor records cs_ windows, SCK edges and sampled sdo bits.
`timescale 1ns/1ps

module tb_spi_master_fifo;

  localparam int DW    = 8;
  localparam int FD    = 16;
  localparam int FDIV  = 4;
  localparam int LW    = 5;
  localparam int FRAME = (2*DW + 2) * FDIV;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW+1:0] wr_data = '0;
  logic          full;
  logic          empty;
  logic [LW-1:0] level;
  logic          busy;
  logic          ovf;
  logic [7:0]    dout;

  always #4 clk = ~clk;

  spi_master_fifo #(
    .DATA_W     (DW),
    .FIFO_DEPTH (FD),
    .FREQDIV    (FDIV),
    .LVL_W      (LW)
  ) dut (
    .clk_125mhz (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .empty      (empty),
    .level      (level),
    .busy       (busy),
    .ovf        (ovf),
    .dout       (dout)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  // Monitor: cs_=dout[0], sdo=dout[1], sck=dout[3]
  int          frames = 0;
  int          low_cnt = 0;
  int          nrise = 0;
  int          nfall = 0;
  logic        prev_cs = 1'b1;
  logic        prev_sck = 1'b0;
  logic [31:0] shbits = '0;
  int          lenq[$];
  logic [7:0]  byteq[$];

  always @(negedge clk) begin
    if (dout[3] && !prev_sck && !dout[0]) begin
      shbits = {shbits[30:0], dout[1]};
      nrise++;
    end
    if (!dout[3] && prev_sck && !dout[0]) nfall++;
    if (!dout[0]) begin
      low_cnt++;
    end else if (!prev_cs) begin
      frames++;
      lenq.push_back(low_cnt);
      byteq.push_back(shbits[7:0]);
      low_cnt = 0;
    end
    prev_cs  = dout[0];
    prev_sck = dout[3];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [DW+1:0] d);
    wr_data = d;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_frames(input int target,
                             input int budget,
                             input string tag);
    int n = 0;
    while (frames < target && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(frames >= target), 32'd1);
  endtask

  int f0;
  int r0;
  int fl0;

  initial begin
    #1 reset = 1'b1;
    idle(3);
    check("rst_dout", dout, 8'h01);
    check("rst_level", level, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    reset = 1'b0;
    tick();
    check("first_clk_dout", dout, 8'h29);

    // Power-on entry
    f0 = frames;
    push(10'h3AF);
    check("pwr_level", level, 1);
    tick();
    check("pwr_dout", dout, 8'hE9);
    check("pwr_empty", empty, 1);
    idle(3);
    check("pwr_busy", busy, 0);
    check("pwr_noframe", frames, f0);

    // Single command frame 0xA5
    f0 = frames; r0 = nrise; fl0 = nfall;
    push(10'h0A5);
    check("cmd_cs_hold", dout[0], 1);
    tick();
    check("cmd_cs_fall", dout[0], 0);
    check("cmd_busy", busy, 1);
    wait_frames(f0 + 1, FRAME + 20, "cmd_timeout");
    check("cmd_len", lenq[f0], FRAME);
    check("cmd_byte", byteq[f0], 8'hA5);
    check("cmd_rise", nrise - r0, 8);
    check("cmd_fall", nfall - fl0, 8);
    check("cmd_dc", dout[4], 0);
    check("cmd_busy_end", busy, 0);

    // Overflow: stall frame, then 17 pushes
    f0 = frames;
    push(10'h0FF);
    wr_en = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wr_data = {1'b0, ~i[0], 8'(8'h10 + i)};
      tick();
    end
    wr_en = 1'b0;
    check("ovf_level", level, 16);
    check("ovf_full", full, 1);
    check("ovf_flag", ovf, 1);
    wait_frames(f0 + 17, 17 * (FRAME + 4) + 50,
                "ovf_timeout");
    idle(3 * FRAME);
    check("ovf_frames", frames - f0, 17);
    check("ovf_stall_byte", byteq[f0], 8'hFF);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("ovf_byte%0d", i),
            byteq[f0 + 1 + i], 8'(8'h10 + i));
    end
    check("ovf_len_last", lenq[f0 + 16], FRAME);
    check("ovf_sticky", ovf, 1);
    check("ovf_drain_empty", empty, 1);
    check("ovf_drain_full", full, 0);

    // Same-D/C data pair followed by a command
    f0 = frames; r0 = nrise;
    push(10'h1FF);
    push(10'h100);
    push(10'h055);
`ifdef SPI_MASTER_BURST_EN
    wait_frames(f0 + 2, 3 * FRAME + 50, "bst_timeout");
    idle(2 * FRAME);
    check("bst_frames", frames - f0, 2);
    check("bst_len0", lenq[f0], (4*DW + 2) * FDIV);
    check("bst_byte0", byteq[f0], 8'h00);
    check("bst_len1", lenq[f0 + 1], FRAME);
    check("bst_byte1", byteq[f0 + 1], 8'h55);
`else
    wait_frames(f0 + 3, 3 * FRAME + 50, "bst_timeout");
    idle(2 * FRAME);
    check("bst_frames", frames - f0, 3);
    check("bst_len0", lenq[f0], FRAME);
    check("bst_byte0", byteq[f0], 8'hFF);
    check("bst_byte1", byteq[f0 + 1], 8'h00);
    check("bst_byte2", byteq[f0 + 2], 8'h55);
`endif
    check("bst_rise", nrise - r0, 24);
    check("bst_dc", dout[4], 0);

    // Reset in the middle of a frame
    push(10'h1C3);
    push(10'h0E7);
    idle(20);
    check("mid_busy", busy, 1);
    check("mid_cs", dout[0], 0);
    check("mid_level", level, 1);
    reset = 1'b1;
    tick();
    check("mid_rst_dout", dout, 8'h01);
    check("mid_rst_level", level, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_ovf", ovf, 0);
    reset = 1'b0;
    tick();
    check("mid_rel_dout", dout, 8'h29);
    f0 = frames;
    push(10'h012);
    wait_frames(f0 + 1, FRAME + 20, "post_timeout");
    idle(2 * FRAME);
    check("post_frames", frames - f0, 1);
    check("post_len", lenq[f0], FRAME);
    check("post_byte", byteq[f0], 8'h12);
    check("post_dc", dout[4], 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
